// File: rtl/display_buffer_writer_if.sv
// CPU-side PIO command/data bus and frame-buffer RAM write port of the
// display buffer writer. The master drives PIO words and observes the
// RAM writes; the slave (the writer) consumes PIO words and issues writes.
interface display_buffer_writer_if;
    logic [10:0] display_buffer_addr_export;
    logic [31:0] display_buffer_data_export;
    logic [7:0]  display_buffer_ctrl_export;
    logic        fb_wr_en;
    logic        fb_wr_bank;
    logic [10:0] fb_wr_addr;
    logic [31:0] fb_wr_data;

    modport master (
        output display_buffer_addr_export,
        output display_buffer_data_export,
        output display_buffer_ctrl_export,
        input  fb_wr_en,
        input  fb_wr_bank,
        input  fb_wr_addr,
        input  fb_wr_data
    );

    modport slave (
        input  display_buffer_addr_export,
        input  display_buffer_data_export,
        input  display_buffer_ctrl_export,
        output fb_wr_en,
        output fb_wr_bank,
        output fb_wr_addr,
        output fb_wr_data
    );
endinterface

// File: rtl/display_buffer_writer.sv
// Double-buffered LED frame-buffer writer. Software toggles PIO control bits
// to request single-word writes, a full-bank CLEAR sweep, or a bank SWAP that
// is deferred to the next scanner frame boundary. Writes always target the
// back bank (the one the scanner is not displaying).
module display_buffer_writer (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    display_buffer_writer_if.slave        bus,
    input  logic                          scan_frame_start,
    output logic                          scan_bank,
    output logic                          swap_pending,
    output logic                          busy
);
    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [2:0]  sync1_r, sync2_r, hist_r;
    logic [2:0]  cmd_edge_s;
    logic [1:0]  prime_cnt_r, prime_cnt_s;
    logic [10:0] clr_cnt_r, clr_cnt_s;
    logic        wr_en_r, wr_en_s;
    logic        wr_bank_r;
    logic [10:0] wr_addr_r, wr_addr_s;
    logic [31:0] wr_data_r, wr_data_s;
    logic        scan_bank_r, scan_bank_s;
    logic        pending_r, pending_s;
    logic        busy_r, busy_s;
    logic        swap_go_s, swap_edge_s;
    logic        ctrl_unused_s;

    // Reserved command bits are intentionally not acted upon.
    assign ctrl_unused_s = ^bus.display_buffer_ctrl_export[7:3];

    // Either polarity of change on a synchronized bit is a command.
    assign cmd_edge_s  = sync2_r ^ hist_r;
    assign swap_edge_s = cmd_edge_s[1] && (state_r != ST_PRIME);
    assign swap_go_s   = (state_r == ST_IDLE) && scan_frame_start && pending_r;

    // Two-flop synchronizers plus edge-detect history; history simply tracks
    // the synchronized value so PRIME absorbs any bits already set at reset.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
            hist_r  <= 3'b000;
        end else begin
            sync1_r <= bus.display_buffer_ctrl_export[2:0];
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    // Next-state and next-output logic for the write/clear sequencer.
    always_comb begin
        state_s     = state_r;
        prime_cnt_s = prime_cnt_r;
        clr_cnt_s   = clr_cnt_r;
        wr_en_s     = 1'b0;
        wr_addr_s   = wr_addr_r;
        wr_data_s   = wr_data_r;
        case (state_r)
            ST_PRIME: begin
                if (prime_cnt_r == 2'd2) begin
                    state_s     = ST_IDLE;
                    prime_cnt_s = 2'd0;
                end else begin
                    prime_cnt_s = prime_cnt_r + 2'd1;
                end
            end
            ST_IDLE: begin
                // CLEAR outranks a simultaneous WR, which is then lost.
                if (cmd_edge_s[2]) begin
                    state_s   = ST_CLEAR;
                    clr_cnt_s = 11'd0;
                    wr_en_s   = 1'b1;
                    wr_addr_s = 11'd0;
                    wr_data_s = 32'd0;
                end else if (cmd_edge_s[0]) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = bus.display_buffer_addr_export;
                    wr_data_s = bus.display_buffer_data_export;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                // clr_cnt_r is the address currently being written.
                if (clr_cnt_r == 11'd2047) begin
                    state_s = ST_IDLE;
                end else begin
                    clr_cnt_s = clr_cnt_r + 11'd1;
                    wr_en_s   = 1'b1;
                    wr_addr_s = clr_cnt_r + 11'd1;
                    wr_data_s = 32'd0;
                end
            end
            default: begin
                state_s     = ST_PRIME;
                prime_cnt_s = 2'd0;
            end
        endcase
        busy_s = (state_s == ST_CLEAR);
    end

    // Swap bookkeeping: a pending swap executes only at an IDLE frame start.
    always_comb begin
        scan_bank_s = scan_bank_r;
        pending_s   = pending_r;
        if (swap_go_s) begin
            scan_bank_s = ~scan_bank_r;
            pending_s   = 1'b0;
        end else if (swap_edge_s) begin
            pending_s = 1'b1;
        end else begin
            pending_s = pending_r;
        end
    end

    // State and output registers; write bank lags scan bank by one cycle so a
    // write launched on a swap edge still lands in the pre-swap back bank.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_r     <= ST_PRIME;
            prime_cnt_r <= 2'd0;
            clr_cnt_r   <= 11'd0;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= 11'd0;
            wr_data_r   <= 32'd0;
            scan_bank_r <= 1'b0;
            wr_bank_r   <= 1'b1;
            pending_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            prime_cnt_r <= prime_cnt_s;
            clr_cnt_r   <= clr_cnt_s;
            wr_en_r     <= wr_en_s;
            wr_addr_r   <= wr_addr_s;
            wr_data_r   <= wr_data_s;
            scan_bank_r <= scan_bank_s;
            wr_bank_r   <= ~scan_bank_r;
            pending_r   <= pending_s;
            busy_r      <= busy_s;
        end
    end

    assign bus.fb_wr_en   = wr_en_r;
    assign bus.fb_wr_bank = wr_bank_r;
    assign bus.fb_wr_addr = wr_addr_r;
    assign bus.fb_wr_data = wr_data_r;
    assign scan_bank      = scan_bank_r;
    assign swap_pending   = pending_r;
    assign busy           = busy_r;
endmodule

// File: tb/tb_display_buffer_writer.sv
// Self-checking bench for display_buffer_writer: directed scenarios followed
// by a randomized phase, every cycle compared against a behavioural model.
module tb_display_buffer_writer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic sfs;
    logic scan_bank_o, pending_o, busy_o;

    display_buffer_writer_if bus();

    display_buffer_writer dut (
        .clk_clk          (clk),
        .reset_reset      (rst),
        .bus              (bus.slave),
        .scan_frame_start (sfs),
        .scan_bank        (scan_bank_o),
        .swap_pending     (pending_o),
        .busy             (busy_o)
    );

    // Behavioural model state
    int          prime_left;
    int          clear_idx;      // -1 when no sweep, else address being written
    bit          m_pending, m_bank, m_wbank, m_en, m_busy;
    logic [10:0] m_addr;
    logic [31:0] m_data;
    logic [2:0]  smp1, smp2, smp3; // ctrl[2:0] as sampled 1,2,3 edges ago

    int checks = 0, passes = 0, fails = 0;
    int wr_count = 0, busy_count = 0, cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Model update for one rising edge using the inputs held across it.
    task automatic model_edge();
        logic [2:0] cmd;
        bit prime, idle;
        if (rst) begin
            prime_left = 3; clear_idx = -1;
            m_pending = 1'b0; m_bank = 1'b0; m_wbank = 1'b1;
            m_en = 1'b0; m_addr = 11'd0; m_data = 32'd0; m_busy = 1'b0;
            smp1 = 3'd0; smp2 = 3'd0; smp3 = 3'd0;
        end else begin
            cmd   = smp2 ^ smp3;
            prime = (prime_left > 0);
            idle  = !prime && (clear_idx < 0);
            m_wbank = ~m_bank;
            if (idle && sfs && m_pending) begin
                m_bank = ~m_bank; m_pending = 1'b0;
            end else if (!prime && cmd[1]) begin
                m_pending = 1'b1;
            end
            m_en = 1'b0;
            if (prime) begin
                prime_left--;
            end else if (clear_idx >= 0) begin
                if (clear_idx == 2047) clear_idx = -1;
                else begin
                    clear_idx++; m_en = 1'b1; m_addr = clear_idx[10:0]; m_data = 32'd0;
                end
            end else if (cmd[2]) begin
                clear_idx = 0; m_en = 1'b1; m_addr = 11'd0; m_data = 32'd0;
            end else if (cmd[0]) begin
                m_en = 1'b1;
                m_addr = bus.display_buffer_addr_export;
                m_data = bus.display_buffer_data_export;
            end
            m_busy = (clear_idx >= 0);
            smp3 = smp2; smp2 = smp1; smp1 = bus.display_buffer_ctrl_export[2:0];
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        if (bus.fb_wr_en) wr_count++;
        if (busy_o) busy_count++;
        chk("outputs",
            {16'd0, bus.fb_wr_en, bus.fb_wr_bank, bus.fb_wr_addr, bus.fb_wr_data,
             scan_bank_o, pending_o, busy_o},
            {16'd0, m_en, m_wbank, m_addr, m_data, m_bank, m_pending, m_busy});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic toggle(input int b);
        bus.display_buffer_ctrl_export[b] = ~bus.display_buffer_ctrl_export[b];
    endtask

    int  w0, b0;
    bit  found;

    initial begin
        rst = 1'b1; sfs = 1'b0;
        bus.display_buffer_addr_export = 11'd0;
        bus.display_buffer_data_export = 32'd0;
        bus.display_buffer_ctrl_export = 8'h07;
        run(2);
        chk("reset_en", {63'd0, bus.fb_wr_en}, 64'd0);
        chk("reset_bank", {62'd0, bus.fb_wr_bank, scan_bank_o}, 64'd2);

        // Ctrl bits already set at reset release must not act.
        rst = 1'b0;
        w0 = wr_count;
        run(10);
        chk("prime_no_wr", wr_count - w0, 64'd0);
        chk("prime_no_pending", {63'd0, pending_o}, 64'd0);

        // Single word write.
        bus.display_buffer_addr_export = 11'h123;
        bus.display_buffer_data_export = 32'hDEADBEEF;
        toggle(0);
        w0 = wr_count;
        run(2);
        chk("wr_not_early", {63'd0, bus.fb_wr_en}, 64'd0);
        cycle();
        chk("wr_word", {20'd0, bus.fb_wr_en, bus.fb_wr_bank, bus.fb_wr_addr, bus.fb_wr_data},
            {20'd0, 1'b1, 1'b1, 11'h123, 32'hDEADBEEF});
        run(4);
        chk("wr_once", wr_count - w0, 64'd1);

        // CLEAR sweep with a WR that must be dropped.
        w0 = wr_count; b0 = busy_count;
        toggle(2);
        run(100);
        bus.display_buffer_addr_export = 11'h555;
        bus.display_buffer_data_export = 32'h12345678;
        toggle(0);
        run(2100);
        chk("clear_writes", wr_count - w0, 64'd2048);
        chk("clear_busy", busy_count - b0, 64'd2048);

        // Two SWAP toggles, two frame starts: one swap only.
        toggle(1); run(5); toggle(1); run(6);
        chk("swap_pending_set", {63'd0, pending_o}, 64'd1);
        sfs = 1'b1; cycle(); sfs = 1'b0;
        run(3);
        sfs = 1'b1; cycle(); sfs = 1'b0;
        run(3);
        chk("swap_once", {61'd0, scan_bank_o, bus.fb_wr_bank, pending_o}, 64'h4);

        // SWAP during CLEAR waits for the first frame start after the sweep.
        toggle(2); run(10); toggle(1);
        for (int i = 0; i < 3000; i++) begin
            sfs = ((i % 500) == 499);
            cycle();
            if (i == 2400) chk("swap_held", {62'd0, scan_bank_o, pending_o}, 64'h3);
        end
        sfs = 1'b0;
        chk("swap_after_clear", {62'd0, scan_bank_o, pending_o}, 64'h0);

        // Reset in the middle of a sweep aborts it.
        toggle(2);
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            cycle();
            if (m_busy && m_addr == 11'd1000) found = 1'b1;
        end
        chk("sweep_reached_1000", {63'd0, found}, 64'd1);
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("abort_outputs", {16'd0, bus.fb_wr_en, bus.fb_wr_bank, bus.fb_wr_addr, bus.fb_wr_data,
                              scan_bank_o, pending_o, busy_o}, {16'd0, 1'b0, 1'b1, 43'd0, 3'd0});
        w0 = wr_count;
        run(30);
        chk("abort_no_writes", wr_count - w0, 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bus.display_buffer_addr_export = 11'($urandom);
            bus.display_buffer_data_export = $urandom;
            bus.display_buffer_ctrl_export[7:3] = 5'($urandom);
            if ($urandom_range(0, 7) == 0)    toggle(0);
            if ($urandom_range(0, 29) == 0)   toggle(1);
            if ($urandom_range(0, 1499) == 0) toggle(2);
            sfs = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 2499) == 0);
            cycle();
        end
        rst = 1'b0; sfs = 1'b0;
        run(5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
